id_hazard_unit: RTL and testbench

Decode-stage hazard controller for the 5-stage MIPS pipeline. It is the consumer end of the ID/EXE and EXE/MEM pipeline-register outputs. From the EXE-stage and MEM-stage write-back controls and destination registers it produces:
- ID-stage operand forwarding selects;
- the load-use stall and bubble into the ID/EXE register;
- a whole-pipeline freeze while data memory is busy.

It keeps a small cause-tracking state machine, a stall watchdog, and optional stall statistics.

---
 rtl/id_hazard_unit.sv | 179 +++++++++++++++++
 tb/tb_id_hazard_unit.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/id_hazard_unit.sv
// ---------------------------------------------------------------------------
// id_hazard_unit
//
// Decode-stage hazard controller for a 5-stage MIPS pipeline. It looks at the
// write-back controls and destination registers of the instructions currently
// in EXE and MEM. From these it produces:
//   - ID-stage operand forwarding selects,
//   - the load-use stall and the bubble injected into ID/EXE,
//   - a whole-pipeline freeze while data memory is busy.
// It also keeps a cause-tracking state register and a stall watchdog.
//
// Optional feature macro: HAZARD_STATS_EN
//   When defined, the lu_count / wait_count statistics outputs are added.
//
// Parameters:
//   MAX_STALL  consecutive stalled cycles after which hang latches (2..255)
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   rs, rt                ID source register numbers
//   use_rs, use_rt        ID instruction actually reads rs / rt
//   ewreg, em2reg         EXE writes regfile / EXE is a load
//   edestReg              EXE destination register
//   mwreg, mm2reg         MEM writes regfile / MEM is a load
//   mdestReg              MEM destination register
//   dmem_wait             data memory not ready this cycle
//   fwda, fwdb            operand selects: 00 regfile, 01 EXE ALU,
//                         10 MEM ALU, 11 MEM load data
//   stall                 hold PC and IF/ID
//   bubble                zero the control bits entering ID/EXE
//   freeze                hold every pipeline register
//   state                 00 RUN, 01 LSTALL, 10 MWAIT
//   hang                  sticky watchdog flag
//   lu_count, wait_count  (HAZARD_STATS_EN only) saturating event counters
// ---------------------------------------------------------------------------
module id_hazard_unit #(
   parameter int unsigned MAX_STALL = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  rs,
   input  logic [4:0]  rt,
   input  logic        use_rs,
   input  logic        use_rt,
   input  logic        ewreg,
   input  logic        em2reg,
   input  logic [4:0]  edestReg,
   input  logic        mwreg,
   input  logic        mm2reg,
   input  logic [4:0]  mdestReg,
   input  logic        dmem_wait,
   output logic [1:0]  fwda,
   output logic [1:0]  fwdb,
   output logic        stall,
   output logic        bubble,
   output logic        freeze,
   output logic [1:0]  state,
`ifdef HAZARD_STATS_EN
   output logic [31:0] lu_count,
   output logic [31:0] wait_count,
`endif
   output logic        hang
);

   typedef enum logic [1:0] {
      ST_RUN    = 2'b00,
      ST_LSTALL = 2'b01,
      ST_MWAIT  = 2'b10
   } state_t;

   localparam logic [7:0] MAX_STALL_C = 8'(MAX_STALL);

   state_t     state_q, state_d;
   logic [7:0] wdog_q, wdog_d;
   logic       hang_q, hang_d;

   // Register 0 is hard-wired to zero, so it never matches.
   function automatic logic reg_match(input logic wr, input logic [4:0] dst,
                                      input logic [4:0] src);
      return wr && (dst != 5'd0) && (dst == src);
   endfunction

   // An EXE load match selects the regfile: the ID instruction is bubbled
   // this cycle and picks the loaded value from MEM on the next.
   function automatic logic [1:0] fwd_sel(input logic used, input logic [4:0] src,
                                          input logic e_wr, input logic e_ld,
                                          input logic [4:0] e_dst,
                                          input logic m_wr, input logic m_ld,
                                          input logic [4:0] m_dst);
      logic [1:0] sel;
      sel = 2'b00;
      if (used) begin
         if (reg_match(e_wr, e_dst, src))
            sel = e_ld ? 2'b00 : 2'b01;
         else if (reg_match(m_wr, m_dst, src))
            sel = m_ld ? 2'b11 : 2'b10;
      end
      return sel;
   endfunction

   logic       lu;
   logic       stall_raw;
   logic [1:0] fwda_raw, fwdb_raw;

   always_comb begin
      fwda_raw = fwd_sel(use_rs, rs, ewreg, em2reg, edestReg, mwreg, mm2reg, mdestReg);
      fwdb_raw = fwd_sel(use_rt, rt, ewreg, em2reg, edestReg, mwreg, mm2reg, mdestReg);
      lu       = em2reg && ((use_rs && reg_match(ewreg, edestReg, rs)) ||
                            (use_rt && reg_match(ewreg, edestReg, rt)));
      stall_raw = lu || dmem_wait;
   end

   // Reset forces every output low, independent of the inputs.
   always_comb begin
      fwda   = rst ? 2'b00 : fwda_raw;
      fwdb   = rst ? 2'b00 : fwdb_raw;
      freeze = !rst && dmem_wait;
      stall  = !rst && stall_raw;
      // Freeze wins: a frozen ID/EXE must not be overwritten by a bubble.
      bubble = !rst && lu && !dmem_wait;
      state  = rst ? ST_RUN : state_q;
      hang   = !rst && hang_q;
   end

   // Next-state: the cause of the current cycle, same from every state.
   always_comb begin
      state_d = ST_RUN;
      if (dmem_wait)
         state_d = ST_MWAIT;
      else if (lu)
         state_d = ST_LSTALL;

      wdog_d = 8'd0;
      if (stall_raw)
         wdog_d = (wdog_q == 8'hFF) ? 8'hFF : wdog_q + 8'd1;

      hang_d = hang_q || (stall_raw && (wdog_d == MAX_STALL_C));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_RUN;
         wdog_q  <= 8'd0;
         hang_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         wdog_q  <= wdog_d;
         hang_q  <= hang_d;
      end
   end

`ifdef HAZARD_STATS_EN
   logic [31:0] lu_count_q, lu_count_d;
   logic [31:0] wait_count_q, wait_count_d;

   always_comb begin
      lu_count_d = lu_count_q;
      if (lu && !dmem_wait && (lu_count_q != 32'hFFFF_FFFF))
         lu_count_d = lu_count_q + 32'd1;
      wait_count_d = wait_count_q;
      if (dmem_wait && (wait_count_q != 32'hFFFF_FFFF))
         wait_count_d = wait_count_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lu_count_q   <= 32'd0;
         wait_count_q <= 32'd0;
      end else begin
         lu_count_q   <= lu_count_d;
         wait_count_q <= wait_count_d;
      end
   end

   assign lu_count   = rst ? 32'd0 : lu_count_q;
   assign wait_count = rst ? 32'd0 : wait_count_q;
`endif

endmodule

// File: tb/tb_id_hazard_unit.sv
// ---------------------------------------------------------------------------
// tb_id_hazard_unit
//
// Directed self-checking bench for id_hazard_unit (MAX_STALL = 4).
// Inputs are driven #1 after a rising edge; combinational outputs are checked
// #1 later, registered outputs #1 after the following rising edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_id_hazard_unit;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] rs, rt, edestReg, mdestReg;
   logic       use_rs, use_rt, ewreg, em2reg, mwreg, mm2reg, dmem_wait;
   logic [1:0] fwda, fwdb, state;
   logic       stall, bubble, freeze, hang;
`ifdef HAZARD_STATS_EN
   logic [31:0] lu_count, wait_count;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   id_hazard_unit #(.MAX_STALL(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .rs        (rs),
      .rt        (rt),
      .use_rs    (use_rs),
      .use_rt    (use_rt),
      .ewreg     (ewreg),
      .em2reg    (em2reg),
      .edestReg  (edestReg),
      .mwreg     (mwreg),
      .mm2reg    (mm2reg),
      .mdestReg  (mdestReg),
      .dmem_wait (dmem_wait),
      .fwda      (fwda),
      .fwdb      (fwdb),
      .stall     (stall),
      .bubble    (bubble),
      .freeze    (freeze),
      .state     (state),
`ifdef HAZARD_STATS_EN
      .lu_count  (lu_count),
      .wait_count(wait_count),
`endif
      .hang      (hang)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Check every combinational output plus the registered ones in one line.
   task automatic check_all(input string tag, input logic [1:0] ea, input logic [1:0] eb,
                            input logic es, input logic ebub, input logic efr,
                            input logic [1:0] est, input logic eh);
      check({tag, ".fwda"},   32'(fwda),   32'(ea));
      check({tag, ".fwdb"},   32'(fwdb),   32'(eb));
      check({tag, ".stall"},  32'(stall),  32'(es));
      check({tag, ".bubble"}, 32'(bubble), 32'(ebub));
      check({tag, ".freeze"}, 32'(freeze), 32'(efr));
      check({tag, ".state"},  32'(state),  32'(est));
      check({tag, ".hang"},   32'(hang),   32'(eh));
   endtask

   task automatic clear_inputs();
      rs = 5'd0; rt = 5'd0; use_rs = 1'b0; use_rt = 1'b0;
      ewreg = 1'b0; em2reg = 1'b0; edestReg = 5'd0;
      mwreg = 1'b0; mm2reg = 1'b0; mdestReg = 5'd0;
      dmem_wait = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      clear_inputs();
      tick();
      tick();
      check_all("reset", 2'b00, 2'b00, 0, 0, 0, 2'b00, 0);
      rst = 1'b0;
      tick();
      check_all("idle", 2'b00, 2'b00, 0, 0, 0, 2'b00, 0);

      // EXE ALU forward on rs
      ewreg = 1; em2reg = 0; edestReg = 5'd8; rs = 5'd8; use_rs = 1; rt = 5'd3; use_rt = 1;
      #1 check_all("exe_fwd", 2'b01, 2'b00, 0, 0, 0, 2'b00, 0);
      tick();
      check("exe_fwd.state", 32'(state), 32'd0);
      use_rs = 0;
      #1 check("no_use_rs.fwda", 32'(fwda), 32'd0);
      tick();

      // Load-use on rt, then load reaches MEM
      clear_inputs();
      ewreg = 1; em2reg = 1; edestReg = 5'd9; rt = 5'd9; use_rt = 1; use_rs = 1;
      #1 check_all("lu", 2'b00, 2'b00, 1, 1, 0, 2'b00, 0);
      tick();
      check("lu.state", 32'(state), 32'd1);
      ewreg = 0; em2reg = 0; edestReg = 5'd0;
      mwreg = 1; mm2reg = 1; mdestReg = 5'd9;
      #1 check_all("lu_mem", 2'b00, 2'b11, 0, 0, 0, 2'b01, 0);
      tick();
      check("lu_mem.state", 32'(state), 32'd0);

      // EXE and MEM both write $5: EXE wins, then MEM when EXE dest is $0
      clear_inputs();
      ewreg = 1; edestReg = 5'd5; mwreg = 1; mdestReg = 5'd5;
      rs = 5'd5; rt = 5'd5; use_rs = 1; use_rt = 1;
      #1 check_all("both", 2'b01, 2'b01, 0, 0, 0, 2'b00, 0);
      edestReg = 5'd0;
      #1 check_all("mem_only", 2'b10, 2'b10, 0, 0, 0, 2'b00, 0);

      // Register 0 never forwards nor hazards
      clear_inputs();
      ewreg = 1; em2reg = 1; edestReg = 5'd0; mwreg = 1; mdestReg = 5'd0;
      use_rs = 1; use_rt = 1;
      #1 check_all("reg0", 2'b00, 2'b00, 0, 0, 0, 2'b00, 0);
      tick();

      // Load-use during 3 cycles of dmem_wait, then one bubble cycle
      clear_inputs();
      ewreg = 1; em2reg = 1; edestReg = 5'd7; rs = 5'd7; use_rs = 1; dmem_wait = 1;
      for (int i = 0; i < 3; i++) begin
         #1 check_all($sformatf("wait%0d", i), 2'b00, 2'b00, 1, 0, 1,
                      (i == 0) ? 2'b00 : 2'b10, 0);
         tick();
      end
      check("wait.state", 32'(state), 32'd2);
      dmem_wait = 0;
      #1 check_all("post_wait", 2'b00, 2'b00, 1, 1, 0, 2'b10, 0);
      tick();
      // Fourth consecutive stalled edge with MAX_STALL = 4
      check("post_wait.state", 32'(state), 32'd1);
      check("post_wait.hang", 32'(hang), 32'd1);
`ifdef HAZARD_STATS_EN
      check("stats.lu_count", lu_count, 32'd2);
      check("stats.wait_count", wait_count, 32'd3);
`endif

      // Reset with hazards present drives everything to 0
      mwreg = 1; mdestReg = 5'd8; rt = 5'd8; use_rt = 1; dmem_wait = 1;
      rst = 1;
      #1 check_all("rst_live", 2'b00, 2'b00, 0, 0, 0, 2'b00, 0);
      tick();
      check_all("rst_edge", 2'b00, 2'b00, 0, 0, 0, 2'b00, 0);
      rst = 0;
      clear_inputs();
      tick();
      check_all("after_rst", 2'b00, 2'b00, 0, 0, 0, 2'b00, 0);

      // Watchdog: dmem_wait for 6 cycles
      dmem_wait = 1;
      for (int i = 1; i <= 6; i++) begin
         tick();
         check($sformatf("wdog%0d.hang", i), 32'(hang), (i >= 4) ? 32'd1 : 32'd0);
      end
      check("wdog.state", 32'(state), 32'd2);
      dmem_wait = 0;
      tick();
      check("wdog_drop.hang", 32'(hang), 32'd1);
      check("wdog_drop.state", 32'(state), 32'd0);
      rst = 1;
      tick();
      check_all("wdog_rst", 2'b00, 2'b00, 0, 0, 0, 2'b00, 0);
      rst = 0;
      tick();
      check("wdog_rst_rel.hang", 32'(hang), 32'd0);

`ifdef HAZARD_STATS_EN
      // Saturation of lu_count from near all-ones
      dut.lu_count_q = 32'hFFFF_FFFE;
      ewreg = 1; em2reg = 1; edestReg = 5'd4; rs = 5'd4; use_rs = 1;
      tick();
      check("sat1.lu_count", lu_count, 32'hFFFF_FFFF);
      tick();
      check("sat2.lu_count", lu_count, 32'hFFFF_FFFF);
      clear_inputs();
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Safety net so the run always terminates.
   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
